// File: rtl/sbox_if.sv
// Valid/ready block channel for the AES byte-substitution engine.
// Carries the input block with its mode and the finished result.
interface sbox_if #(
  parameter int NBYTES = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   in_data;
  logic                  in_inv;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sbox_engine.sv
// Time-multiplexed AES SubBytes / InvSubBytes / SubWord engine.
// LANES shared S-boxes process an NBYTES block over NBYTES/LANES beats.
module sbox_engine #(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  sbox_if.slave  bus
);
  localparam int LDIV  = (LANES < 1) ? 1 : LANES;
  localparam int BEATS = NBYTES / LDIV;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int W     = 8 * NBYTES;

  if (LANES < 1 || NBYTES < 1 || (NBYTES % LDIV) != 0) begin : g_bad
    $error("sbox_engine: LANES must be >= 1 and divide NBYTES");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           mode;
  logic [W-1:0]   src;
  logic [W-1:0]   res;
  logic [W-1:0]   res_nxt;
  logic [W-1:0]   dout;
  logic           last;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h01;
    t = a;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] v,
    input int         n
  );
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] x,
    input logic       inv
  );
    logic [7:0] y;
    if (inv) begin
      y = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
      return ginv(y);
    end
    y = ginv(x);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3)
             ^ rotl(y, 4) ^ 8'h63;
  endfunction

  assign last = (cnt == CW'(BEATS - 1));

  always_comb begin
    res_nxt = res;
    for (int l = 0; l < LANES; l++) begin
      res_nxt[(int'(cnt) * LANES + l) * 8 +: 8] =
        sbox(src[(int'(cnt) * LANES + l) * 8 +: 8], mode);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_nxt = BUSY;
      BUSY: if (last) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      mode  <= 1'b0;
      src   <= '0;
      res   <= '0;
      dout  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            src  <= bus.in_data;
            mode <= bus.in_inv;
            cnt  <= '0;
          end
        end
        BUSY: begin
          res <= res_nxt;
          cnt <= last ? '0 : cnt + 1'b1;
          // out_data only moves when the whole block is finished
          if (last) dout <= res_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = dout;
endmodule

// File: tb/tb_sbox_engine.sv
// Bench for sbox_engine: table-driven reference model with a scoreboard,
// directed FIPS-197 vectors, backpressure, back-to-back, reset abort.
module tb_sbox_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  sbox_if #(.NBYTES(16)) bus ();
  sbox_if #(.NBYTES(4))  sw ();
  sbox_if #(.NBYTES(16)) sq ();

  sbox_engine #(.NBYTES(16), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  sbox_engine #(.NBYTES(4), .LANES(4)) dut_sw (
    .clk(clk), .rst_n(rst_n), .bus(sw)
  );
  sbox_engine #(.NBYTES(16), .LANES(1)) dut_sq (
    .clk(clk), .rst_n(rst_n), .bus(sq)
  );

  localparam logic [0:255][7:0] FT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] ftab [256];
  logic [7:0] itab [256];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(
    input logic [127:0] d,
    input logic         inv
  );
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = inv ? itab[d[8*i +: 8]] : ftab[d[8*i +: 8]];
    return r;
  endfunction

  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           prev_acc = -1;
  bit           b2b = 1'b0;
  bit           seen = 1'b0;
  logic [127:0] held;
  logic [127:0] last_out;
  int           n_out = 0;

  // scoreboard on the main instance
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      seen = 1'b0;
      prev_acc = -1;
    end else begin
      check("rdy", bus.in_ready, exp_q.size() == 0);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("stale", bus.out_valid, 0);
        end else if (!seen) begin
          seen = 1'b1;
          held = bus.out_data;
          check("lat", cyc - acc_q[0], 4);
          check("data", bus.out_data, exp_q[0]);
        end else begin
          check("hold", bus.out_data, held);
        end
        if (bus.out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          seen = 1'b0;
          last_out = held;
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (b2b && prev_acc >= 0)
          check("gap", cyc + 1 - prev_acc, 6);
        prev_acc = b2b ? cyc + 1 : -1;
        exp_q.push_back(model(bus.in_data, bus.in_inv));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic inv);
    int k = 0;
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) check("send_to", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_inv   = inv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.in_inv   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out(input bit bp);
    int n0 = n_out;
    int k = 0;
    while (n_out == n0 && k < 100) begin
      @(posedge clk); #1;
      bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      k++;
    end
    check("out_to", n_out - n0, 1);
    bus.out_ready = 1'b1;
  endtask

  logic [127:0] d, r, seq;
  logic         inv;
  int           k, n0, lat;

  initial begin
    #200000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ftab[i] = FT[i];
      itab[FT[i]] = 8'(i);
    end
    for (int i = 0; i < 16; i++) seq[8*i +: 8] = 8'(i);
    bus.in_valid = 0; bus.in_data = '0; bus.in_inv = 0; bus.out_ready = 1;
    sw.in_valid = 0;  sw.in_data = '0;  sw.in_inv = 0;  sw.out_ready = 1;
    sq.in_valid = 0;  sq.in_data = '0;  sq.in_inv = 0;  sq.out_ready = 1;

    #12;
    check("rst_rdy", bus.in_ready, 1);
    check("rst_ov", bus.out_valid, 0);
    check("rst_od", bus.out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    send(seq, 1'b0);
    wait_out(1'b0);
    check("fwd", last_out, 128'h76abd7fe2b670130c56f6bf27b777c63);
    r = last_out;
    send(r, 1'b1);
    wait_out(1'b0);
    check("inv", last_out, seq);
    send({16{8'hff}}, 1'b0);
    wait_out(1'b0);
    check("ff", last_out, {16{8'h16}});
    send({16{8'h16}}, 1'b1);
    wait_out(1'b0);
    check("16", last_out, {16{8'hff}});

    // backpressure with input churn
    bus.out_ready = 1'b0;
    send(seq, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_ov", bus.out_valid, 1);
    repeat (10) begin
      @(posedge clk); #1;
      bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.in_inv   = ~bus.in_inv;
      bus.in_valid = 1'($urandom_range(0, 1));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_drop", bus.out_valid, 0);
    check("bp_rdy", bus.in_ready, 1);
    check("bp_data", last_out, model(seq, 1'b1));

    // back-to-back, in_valid held high
    b2b = 1'b1;
    n0 = n_out;
    bus.in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      bus.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.in_inv  = 1'(b);
      k = 0;
      while (!bus.in_ready && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    k = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("b2b_n", n_out - n0, 3);
    b2b = 1'b0;

    repeat (20) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv = 1'($urandom_range(0, 1));
      send(d, inv);
      wait_out(1'b1);
      check("rnd", last_out, model(d, inv));
    end

    // reset during beat 2
    send({16{8'h42}}, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("ab_rdy", bus.in_ready, 1);
    check("ab_ov", bus.out_valid, 0);
    check("ab_od", bus.out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("ab_none", bus.out_valid, 0);
    send({16{8'h53}}, 1'b0);
    wait_out(1'b0);
    check("ab_53", last_out, {16{8'hed}});

    // SubWord configuration, single beat
    check("sw_rdy", sw.in_ready, 1);
    sw.in_valid = 1'b1;
    sw.in_data  = 32'hff635300;
    sw.in_inv   = 1'b0;
    @(posedge clk); #1;
    sw.in_valid = 1'b0;
    lat = 0;
    while (!sw.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("sw_lat", lat, 1);
    check("sw_data", sw.out_data, 32'h16fbed63);
    @(posedge clk); #1;
    check("sw_drop", sw.out_valid, 0);

    // single lane, sixteen beats
    check("sq_rdy", sq.in_ready, 1);
    sq.in_valid = 1'b1;
    sq.in_data  = seq;
    sq.in_inv   = 1'b0;
    @(posedge clk); #1;
    sq.in_valid = 1'b0;
    lat = 0;
    while (!sq.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("sq_lat", lat, 16);
    check("sq_data", sq.out_data, 128'h76abd7fe2b670130c56f6bf27b777c63);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
